shift_sequencer: RTL and testbench

Multicycle controller that performs an N-bit shift or rotate on a DATA_W operand, one bit position per clock. It sequences the processor's shift unit on behalf of the ALU/control path and reports Z/C flags. A start/busy/done handshake gives the main controller a variable-latency operation. Latency equals the shift count plus one.

---
 rtl/shift_pkg.sv | 26 ++
 rtl/shift_step_unit.sv | 41 ++++
 rtl/shift_sequencer.sv | 119 +++++++++++
 tb/tb_shift_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and width constants for the shift sequencer and its step unit.
package shift_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultCntW  = 4;

  // Encodings match the opcode port.
  typedef enum logic [1:0] {
    OpShl = 2'b00,
    OpShr = 2'b01,
    OpRol = 2'b10,
    OpRor = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StFin   = 2'b10
  } seq_state_t;

  // True for the opcodes that shift in zeros rather than wrap around.
  function automatic logic is_logical(input shift_op_t op);
    return (op == OpShl) || (op == OpShr);
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-position shift/rotate with carry-out of the bit moved out.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic [DATA_W-1:0] work,
  input  shift_op_t         op,
  output logic [DATA_W-1:0] work_next,
  output logic              carry
);

  // One step of the selected operation.
  always_comb begin
    work_next = work;
    carry     = 1'b0;
    unique case (op)
      OpShl: begin
        work_next = {work[DATA_W-2:0], 1'b0};
        carry     = work[DATA_W-1];
      end
      OpShr: begin
        work_next = {1'b0, work[DATA_W-1:1]};
        carry     = work[0];
      end
      OpRol: begin
        work_next = {work[DATA_W-2:0], work[DATA_W-1]};
        carry     = work[DATA_W-1];
      end
      OpRor: begin
        work_next = {work[0], work[DATA_W-1:1]};
        carry     = work[0];
      end
      default: begin
        work_next = work;
        carry     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle shift/rotate controller: one bit position per clock, start/busy/done
// handshake, Z/C flags held from completion until the next accepted start.
// Optional build macro SHIFT_EARLY_EXIT_EN: logical shifts of an all-zero working
// value finish immediately (same result and flags, shorter latency).
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned CNT_W  = DefaultCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        opcode,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  shift_count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] shift_out,
  output logic              Z,
  output logic              C
);

  seq_state_t        state_q;
  shift_op_t         op_q;
  logic [DATA_W-1:0] work_q;
  logic [CNT_W-1:0]  rem_q;
  logic              z_q;
  logic              c_q;
  logic              done_q;
  logic              busy_q;

  logic [DATA_W-1:0] step_work;
  logic              step_carry;
  logic              early_exit;

  shift_step_unit #(
    .DATA_W (DATA_W)
  ) u_step (
    .work      (work_q),
    .op        (op_q),
    .work_next (step_work),
    .carry     (step_carry)
  );

`ifdef SHIFT_EARLY_EXIT_EN
  // A zero operand stays zero under logical shifts, and every further carry is 0.
  assign early_exit = is_logical(op_q) && (work_q == '0);
`else
  assign early_exit = 1'b0;
`endif

  // Sequencer FSM with registered datapath, flags and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpShl;
      work_q  <= '0;
      rem_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            work_q <= data_in;
            op_q   <= shift_op_t'(opcode);
            rem_q  <= shift_count;
            c_q    <= 1'b0;
            busy_q <= 1'b1;
            if (shift_count != '0) begin
              state_q <= StShift;
            end else begin
              state_q <= StFin;
              done_q  <= 1'b1;
              z_q     <= (data_in == '0);
            end
          end
        end
        StShift: begin
          if (early_exit) begin
            state_q <= StFin;
            done_q  <= 1'b1;
            c_q     <= 1'b0;
            z_q     <= 1'b1;
          end else begin
            work_q <= step_work;
            c_q    <= step_carry;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
              state_q <= StFin;
              done_q  <= 1'b1;
              z_q     <= (step_work == '0);
            end
          end
        end
        StFin: begin
          // Start is ignored here; return to idle unconditionally.
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign shift_out = work_q;
  assign Z         = z_q;
  assign C         = c_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] opcode;
  logic [7:0] data_in;
  logic [3:0] shift_count;
  logic       busy;
  logic       done;
  logic [7:0] shift_out;
  logic       z;
  logic       c;

  int errors;
  int checks;

  shift_sequencer #(
    .DATA_W (8),
    .CNT_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .data_in     (data_in),
    .shift_count (shift_count),
    .busy        (busy),
    .done        (done),
    .shift_out   (shift_out),
    .Z           (z),
    .C           (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation; lat counts posedges from the sampling edge (1) to done,
  // -1 on timeout. extra counts done pulses in the 4 cycles that follow.
  task automatic run_op(input logic [1:0] op, input logic [7:0] d, input logic [3:0] n,
                        output int lat, output int extra);
    @(negedge clk);
    start       = 1'b1;
    opcode      = op;
    data_in     = d;
    shift_count = n;
    @(posedge clk);
    #1;
    start       = 1'b0;
    // Post-acceptance input changes must not matter.
    opcode      = ~op;
    data_in     = ~d;
    shift_count = 4'hF;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = -1;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
  endtask

  task automatic test_reset();
    int ndone;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, shift_out, z, c} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b out=%h Z=%b C=%b required all 0",
               busy, done, shift_out, z, c);
    end
    // Abort a count-5 SHL mid-SHIFT.
    @(negedge clk);
    start = 1'b1; opcode = 2'b00; data_in = 8'h81; shift_count = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, shift_out, z, c} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_shift: busy=%b done=%b out=%h Z=%b C=%b required all 0",
               busy, done, shift_out, z, c);
    end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_no_done: done pulses=%0d required 0", ndone);
    end
  endtask

  task automatic test_shl();
    int lat, extra;
    run_op(2'b00, 8'h81, 4'd1, lat, extra);
    checks++;
    if (lat !== 2 || extra !== 0) begin
      errors++;
      $display("FAIL shl_latency: lat=%0d extra=%0d required 2/0", lat, extra);
    end
    checks++;
    if ({shift_out, c, z} !== {8'h02, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL shl_result: out=%h C=%b Z=%b required 02/1/0", shift_out, c, z);
    end
  endtask

  task automatic test_shr();
    int lat, extra;
    run_op(2'b01, 8'h01, 4'd1, lat, extra);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL shr_latency: lat=%0d required 2", lat);
    end
    checks++;
    if ({shift_out, c, z} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL shr_result: out=%h C=%b Z=%b required 00/1/1", shift_out, c, z);
    end
  endtask

  task automatic test_rol();
    int lat, extra;
    run_op(2'b10, 8'h81, 4'd3, lat, extra);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL rol_latency: lat=%0d required 4", lat);
    end
    checks++;
    if ({shift_out, c, z} !== {8'h0C, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rol_result: out=%h C=%b Z=%b required 0c/0/0", shift_out, c, z);
    end
  endtask

  task automatic test_zero_count();
    int lat, extra;
    run_op(2'b00, 8'h00, 4'd0, lat, extra);
    checks++;
    if (lat !== 1 || extra !== 0) begin
      errors++;
      $display("FAIL zero_count_latency: lat=%0d extra=%0d required 1/0", lat, extra);
    end
    checks++;
    if ({shift_out, c, z} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL zero_count_result: out=%h C=%b Z=%b required 00/0/1", shift_out, c, z);
    end
  endtask

  task automatic test_ror_wrap();
    int lat, extra;
    run_op(2'b11, 8'h01, 4'd8, lat, extra);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL ror_wrap_latency: lat=%0d required 9", lat);
    end
    checks++;
    if ({shift_out, c, z} !== {8'h01, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ror_wrap_result: out=%h C=%b Z=%b required 01/0/0", shift_out, c, z);
    end
  endtask

  task automatic test_busy_lockout();
    int ndone, done_at;
    logic busy_after;
    ndone = 0; done_at = -1; busy_after = 1'b1;
    // SHL 0x81 by 3 -> 0x08, C=0, Z=0, done after sampling edge 4.
    @(negedge clk);
    start = 1'b1; opcode = 2'b00; data_in = 8'h81; shift_count = 4'd3;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        done_at = i;
      end
      if (i == 1) start = 1'b0;
      if (i == 2) begin
        // Held through the rest of SHIFT and the FIN cycle.
        start = 1'b1; opcode = 2'b11; data_in = 8'hFF; shift_count = 4'd0;
      end
      if (i == 5) begin
        start = 1'b0;
        busy_after = busy;
      end
    end
    checks++;
    if (ndone !== 1 || done_at !== 4) begin
      errors++;
      $display("FAIL lockout_done: pulses=%0d at=%0d required 1 at 4", ndone, done_at);
    end
    checks++;
    if ({shift_out, c, z} !== {8'h08, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL lockout_result: out=%h C=%b Z=%b required 08/0/0", shift_out, c, z);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      errors++;
      $display("FAIL lockout_idle: busy=%b required 0", busy_after);
    end
  endtask

  task automatic test_long_shl();
    int lat, extra, exp_lat;
`ifdef SHIFT_EARLY_EXIT_EN
    exp_lat = 3;
`else
    exp_lat = 10;
`endif
    run_op(2'b00, 8'h80, 4'd9, lat, extra);
    checks++;
    if (lat !== exp_lat || extra !== 0) begin
      errors++;
      $display("FAIL long_shl_latency: lat=%0d extra=%0d required %0d/0", lat, extra, exp_lat);
    end
    checks++;
    if ({shift_out, c, z} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL long_shl_result: out=%h C=%b Z=%b required 00/0/1", shift_out, c, z);
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    start       = 1'b0;
    opcode      = 2'b00;
    data_in     = 8'h00;
    shift_count = 4'd0;
    test_reset();
    test_shl();
    test_shr();
    test_rol();
    test_zero_count();
    test_ror_wrap();
    test_busy_lockout();
    test_long_shl();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
